rob_idx_alloc: RTL and testbench
================================

Name: rob_idx_alloc

Overview:
- Allocation/retire controller for the 96-entry reorder buffer.
- Hands out up to ALLOC_WIDTH consecutive robIdx_t values per cycle to rename/dispatch.
- Retires up to COMMIT_WIDTH entries per cycle from commit.
- Rewinds the tail on a squash.
- Owns the head/tail pointers, the flipped (wrap) bit, occupancy count and backpressure. Sits between rename and the ROB storage.

Parameters:
- ROB_SIZE, 96, number of ROB entries; need not be a power of two.
- ALLOC_WIDTH, 4, maximum allocations per cycle.
- COMMIT_WIDTH, 4, maximum retirements per cycle.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_alloc_req  in  ALLOC_WIDTH  per-lane allocation request; must be contiguous from lane 0.
- o_alloc_ready  out  1  all requested lanes can be granted this cycle.
- o_alloc_idx  out  ALLOC_WIDTH x robIdx_t  index assigned to each lane.
- i_commit_cnt  in  clog2(COMMIT_WIDTH+1)  entries retired this cycle.
- i_squash  in  1  flush all entries from i_squash_idx (inclusive) to tail.
- i_squash_idx  in  robIdx_t  oldest squashed entry.
- o_head  out  robIdx_t  oldest valid entry.
- o_tail  out  robIdx_t  next entry to allocate.
- o_count  out  clog2(ROB_SIZE+1)  occupancy.
- o_empty  out  1  count==0.
- o_full  out  1  count==ROB_SIZE.

Behaviour:
- Reset (async, rst_n low): head=tail={flipped=0,idx=0}, count=0, o_empty=1, o_full=0. o_alloc_ready is combinational and follows its equation.
- Pointer add (k <= max(ALLOC_WIDTH, COMMIT_WIDTH)):
  - sum=idx+k.
  - If sum >= ROB_SIZE: idx=sum-ROB_SIZE and flipped toggles.
  - Otherwise idx=sum and flipped unchanged.
  - Never use modulo by a power of two.
- Distance(a, b):
  - Same flipped bit: b.idx-a.idx.
  - Different flipped bit: ROB_SIZE-a.idx+b.idx.
- Allocation:
  - n=popcount(i_alloc_req).
  - o_alloc_ready = !i_squash && (ROB_SIZE-count >= n).
  - o_alloc_idx[i]=tail+i, combinational, same cycle. Lanes with req=0 drive don't-care.
  - fire = ready && n>0. Grants are all-or-nothing; no partial grant.
  - On fire, tail += n at the next edge.
- Commit:
  - head += i_commit_cnt at the next edge.
  - i_commit_cnt must not exceed count; violation is an assertion failure.
- Count with no squash: count_next = count + (fire?n:0) - i_commit_cnt.
- Squash:
  - tail_next = i_squash_idx.
  - count_next = Distance(head_next, i_squash_idx), where head_next already includes the same-cycle commit.
  - Allocation is blocked that cycle.
  - i_squash_idx must lie in [head_next, tail] (assert).
  - Squash with i_squash_idx==tail is a no-op on tail.
- Simultaneous alloc + commit at full: ready uses the current count, not the freed slots. Commit frees only for the next cycle; no bypass.
- Non-contiguous i_alloc_req is illegal (assert).
- Outputs o_head/o_tail/o_count/o_empty/o_full are registered-state derived; no combinational input-to-output path except o_alloc_ready and o_alloc_idx.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight requests are dropped.

Decomposition:
- Shared core package holds:
  - robIdx_t (existing).
  - ROB_SIZE constant.
  - Functions rob_idx_add(idx,k) and rob_idx_dist(a,b), reused by the ROB and commit logic.
- One natural sub-module: rob_ptr_add (combinational pointer+k with wrap/flip). Instantiated ALLOC_WIDTH times for lane indices, plus once each for head and tail update.

Test Plan:
- Reset, req=4'b0111 -> ready=1, idx {0,0},{0,1},{0,2}; next cycle tail={0,3}, count=3, empty=0.
- Wrap: head={0,10}, tail={0,94} (count=84), req=4'b1111 -> idx {0,94},{0,95},{1,0},{1,1}; next tail={1,2}, count=88.
- Full boundary:
  - count=94, req=4'b0111 -> ready=0, no state change.
  - req=4'b0011 -> ready=1; next count=96, full=1.
- Alloc+commit: count=10, req=4'b0011, commit_cnt=4 -> count=8; head advances 4, tail advances 2.
- Squash+commit: head={0,5}, tail={0,40}, squash_idx={0,20}, commit_cnt=2, req=4'b0001 -> ready=0; next head={0,7}, tail={0,20}, count=13.
- Reset mid-stream: drive rst_n low between edges with count=50 -> head/tail={0,0}, count=0, empty=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rob_idx_alloc_pkg.sv
// Shared ROB index definitions: sizes, the wrapped index type and the
// pointer arithmetic helpers used by allocation and commit logic.
package rob_idx_alloc_pkg;

  localparam int ROB_SIZE     = 96;
  localparam int ALLOC_WIDTH  = 4;
  localparam int COMMIT_WIDTH = 4;

  localparam int IDX_W    = $clog2(ROB_SIZE);
  localparam int CNT_W    = $clog2(ROB_SIZE + 1);
  localparam int CCNT_W   = $clog2(COMMIT_WIDTH + 1);
  localparam int MAX_STEP = (ALLOC_WIDTH > COMMIT_WIDTH) ? ALLOC_WIDTH : COMMIT_WIDTH;
  localparam int STEP_W   = $clog2(MAX_STEP + 1);

  // flipped toggles every time idx wraps past ROB_SIZE-1; it disambiguates
  // full from empty when head and tail share the same idx.
  typedef struct packed {
    logic             flipped;
    logic [IDX_W-1:0] idx;
  } robIdx_t;

  // Advance a pointer by k entries. The ROB is not a power of two, so the
  // wrap is an explicit compare-and-subtract.
  function automatic robIdx_t rob_idx_add(robIdx_t p, logic [STEP_W-1:0] k);
    logic [IDX_W:0] sum;
    robIdx_t        r;
    sum = {1'b0, p.idx} + {{(IDX_W + 1 - STEP_W){1'b0}}, k};
    if (sum >= (IDX_W + 1)'(ROB_SIZE)) begin
      r.idx     = IDX_W'(sum - (IDX_W + 1)'(ROB_SIZE));
      r.flipped = ~p.flipped;
    end else begin
      r.idx     = sum[IDX_W-1:0];
      r.flipped = p.flipped;
    end
    return r;
  endfunction

  // Number of entries from a (inclusive) up to b (exclusive).
  function automatic logic [CNT_W-1:0] rob_idx_dist(robIdx_t a, robIdx_t b);
    logic [CNT_W-1:0] d;
    if (a.flipped == b.flipped) d = CNT_W'(b.idx) - CNT_W'(a.idx);
    else                        d = CNT_W'(ROB_SIZE) - CNT_W'(a.idx) + CNT_W'(b.idx);
    return d;
  endfunction

endpackage

// File: rtl/rob_idx_alloc_if.sv
// Rename-side allocation handshake.
// Handshake: i_alloc_req is a contiguous lane mask from lane 0 (the "valid"
// side); o_alloc_ready is high when every requested lane can be granted. A
// transfer happens on a clock edge where ready is high and the mask is
// non-zero; it is all-or-nothing. o_alloc_idx is valid in the same cycle for
// requested lanes and is don't-care for the others.
interface rob_idx_alloc_if;
  import rob_idx_alloc_pkg::*;

  logic [ALLOC_WIDTH-1:0]          i_alloc_req;
  logic                            o_alloc_ready;
  robIdx_t [ALLOC_WIDTH-1:0]       o_alloc_idx;

  modport master (output i_alloc_req, input  o_alloc_ready, input  o_alloc_idx);
  modport slave  (input  i_alloc_req, output o_alloc_ready, output o_alloc_idx);
endinterface

// File: rtl/rob_idx_alloc_ptr_add.sv
// Combinational ROB pointer + k with wrap and flip.
module rob_ptr_add
  import rob_idx_alloc_pkg::*;
(
  input  robIdx_t           ptr_i,
  input  logic [STEP_W-1:0] k_i,
  output robIdx_t           ptr_o
);

  assign ptr_o = rob_idx_add(ptr_i, k_i);

endmodule

// File: rtl/rob_idx_alloc.sv
// ROB index allocator: owns head/tail/count, grants up to ALLOC_WIDTH
// consecutive indices per cycle, retires commits and rewinds tail on squash.
module rob_idx_alloc
  import rob_idx_alloc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  rob_idx_alloc_if.slave    alloc_if,
  input  logic [CCNT_W-1:0] i_commit_cnt,
  input  logic              i_squash,
  input  robIdx_t           i_squash_idx,
  output robIdx_t           o_head,
  output robIdx_t           o_tail,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_empty,
  output logic              o_full
);

  robIdx_t                head_q, head_d, head_adv;
  robIdx_t                tail_q, tail_d, tail_adv;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [STEP_W-1:0]      alloc_n;
  logic [STEP_W-1:0]      tail_step;
  logic [CNT_W-1:0]       free_slots;
  logic                   alloc_ready;
  logic                   fire;
  logic [ALLOC_WIDTH-1:0] req_plus1;
  robIdx_t [ALLOC_WIDTH-1:0] lane_idx;

  // Count requested lanes.
  always_comb begin
    alloc_n = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) alloc_n = alloc_n + STEP_W'(alloc_if.i_alloc_req[i]);
  end

  // Readiness uses the current count only; same-cycle commits free slots next cycle.
  assign free_slots  = CNT_W'(ROB_SIZE) - count_q;
  assign alloc_ready = !i_squash && (free_slots >= CNT_W'(alloc_n));
  assign fire        = alloc_ready && (alloc_n != '0);
  assign tail_step   = fire ? alloc_n : '0;

  assign alloc_if.o_alloc_ready = alloc_ready;

  // Lane i is offered tail+i.
  for (genvar g = 0; g < ALLOC_WIDTH; g++) begin : g_lane
    rob_ptr_add u_lane_add (
      .ptr_i (tail_q),
      .k_i   (STEP_W'(g)),
      .ptr_o (lane_idx[g])
    );
    assign alloc_if.o_alloc_idx[g] = lane_idx[g];
  end

  rob_ptr_add u_head_add (
    .ptr_i (head_q),
    .k_i   (STEP_W'(i_commit_cnt)),
    .ptr_o (head_adv)
  );

  rob_ptr_add u_tail_add (
    .ptr_i (tail_q),
    .k_i   (tail_step),
    .ptr_o (tail_adv)
  );

  // Next state: squash rewinds tail and recomputes occupancy from the new head.
  always_comb begin
    head_d  = head_adv;
    tail_d  = tail_adv;
    count_d = count_q + CNT_W'(tail_step) - CNT_W'(i_commit_cnt);
    if (i_squash) begin
      tail_d  = i_squash_idx;
      count_d = rob_idx_dist(head_adv, i_squash_idx);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign o_head  = head_q;
  assign o_tail  = tail_q;
  assign o_count = count_q;
  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CNT_W'(ROB_SIZE));

  assign req_plus1 = alloc_if.i_alloc_req + ALLOC_WIDTH'(1);

  a_commit_le_count: assert property (@(posedge clk) disable iff (!rst_n)
    CNT_W'(i_commit_cnt) <= count_q);

  a_req_contiguous: assert property (@(posedge clk) disable iff (!rst_n)
    (alloc_if.i_alloc_req & req_plus1) == '0);

  a_squash_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    i_squash |-> (rob_idx_dist(head_adv, i_squash_idx) <= rob_idx_dist(head_adv, tail_q)));

endmodule

// File: tb/tb_rob_idx_alloc.sv
// Bench for rob_idx_alloc: directed scenarios plus random traffic against a
// sequence-number model (every entry ever allocated gets a linear number).
module tb_rob_idx_alloc;
  import rob_idx_alloc_pkg::*;

  localparam int W = $bits(robIdx_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CCNT_W-1:0] commit_cnt;
  logic              squash;
  robIdx_t           squash_idx;
  robIdx_t           head, tail;
  logic [CNT_W-1:0]  count;
  logic              empty, full;

  rob_idx_alloc_if aif ();

  rob_idx_alloc dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_if     (aif.slave),
    .i_commit_cnt (commit_cnt),
    .i_squash     (squash),
    .i_squash_idx (squash_idx),
    .o_head       (head),
    .o_tail       (tail),
    .o_count      (count),
    .o_empty      (empty),
    .o_full       (full)
  );

  // ---------------- model / scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int m_head = 0;   // sequence number of oldest live entry
  int m_tail = 0;   // sequence number of next entry to allocate
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic robIdx_t seq2idx(input int s);
    robIdx_t r;
    r.idx     = IDX_W'(s % ROB_SIZE);
    r.flipped = ((s / ROB_SIZE) % 2) == 1;
    return r;
  endfunction

  task automatic check_state(input string tag);
    int cnt;
    cnt = m_tail - m_head;
    check_eq({tag, "_head"},  32'(head),  32'(seq2idx(m_head)));
    check_eq({tag, "_tail"},  32'(tail),  32'(seq2idx(m_tail)));
    check_eq({tag, "_count"}, 32'(count), 32'(cnt));
    check_eq({tag, "_empty"}, 32'(empty), 32'(cnt == 0));
    check_eq({tag, "_full"},  32'(full),  32'(cnt == ROB_SIZE));
  endtask

  task automatic set_idle();
    aif.i_alloc_req = '0;
    commit_cnt      = '0;
    squash          = 1'b0;
    squash_idx      = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [ALLOC_WIDTH-1:0] req, input int cc, input bit sq, input int sq_seq);
    int n, cnt;
    bit exp_ready;
    @(negedge clk);
    aif.i_alloc_req = req;
    commit_cnt      = CCNT_W'(cc);
    squash          = sq;
    squash_idx      = seq2idx(sq_seq);
    #1;
    n         = $countones(req);
    cnt       = m_tail - m_head;
    exp_ready = !sq && (ROB_SIZE - cnt >= n);
    check_eq("alloc_ready", 32'(aif.o_alloc_ready), 32'(exp_ready));
    if (exp_ready) begin
      for (int i = 0; i < n; i++) exp_q.push_back(seq2idx(m_tail + i));
      for (int i = 0; i < n; i++) check_eq("alloc_idx", 32'(aif.o_alloc_idx[i]), 32'(exp_q.pop_front()));
    end
    m_head += cc;
    if (sq)             m_tail = sq_seq;
    else if (exp_ready) m_tail += n;
    @(posedge clk);
    #1;
    check_state("step");
    set_idle();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    m_head = 0;
    m_tail = 0;
    check_state("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt, cc, n, sq_seq, cmax;
    bit sq;
    set_idle();
    #1;
    check_state("por");
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // First allocation after reset.
    step(4'b0111, 0, 1'b0, 0);
    check_eq("first_tail", 32'(tail), 32'h03);

    // Wrap: head={0,10}, tail={0,94}.
    apply_reset();
    for (int i = 0; i < 23; i++) step(4'b1111, 0, 1'b0, 0);
    step(4'b0011, 0, 1'b0, 0);
    step(4'b0000, 4, 1'b0, 0);
    step(4'b0000, 4, 1'b0, 0);
    step(4'b0000, 2, 1'b0, 0);
    check_eq("pre_wrap_count", 32'(count), 32'd84);
    step(4'b1111, 0, 1'b0, 0);
    check_eq("wrap_tail", 32'(tail), 32'h82);
    check_eq("wrap_count", 32'(count), 32'd88);

    // Full boundary.
    step(4'b1111, 0, 1'b0, 0);
    step(4'b0011, 0, 1'b0, 0);
    check_eq("count94", 32'(count), 32'd94);
    step(4'b0111, 0, 1'b0, 0);
    check_eq("no_grant_count", 32'(count), 32'd94);
    step(4'b0011, 0, 1'b0, 0);
    check_eq("full_flag", 32'(full), 32'd1);
    // At full a same-cycle commit does not enable allocation.
    step(4'b0001, 1, 1'b0, 0);
    check_eq("full_commit_count", 32'(count), 32'd95);

    // Alloc + commit in the same cycle.
    apply_reset();
    step(4'b1111, 0, 1'b0, 0);
    step(4'b1111, 0, 1'b0, 0);
    step(4'b0011, 0, 1'b0, 0);
    step(4'b0011, 4, 1'b0, 0);
    check_eq("ac_count", 32'(count), 32'd8);

    // Squash + commit: head 5, tail 40, squash at 20, commit 2.
    apply_reset();
    for (int i = 0; i < 10; i++) step(4'b1111, 0, 1'b0, 0);
    step(4'b0000, 4, 1'b0, 0);
    step(4'b0000, 1, 1'b0, 0);
    step(4'b0001, 2, 1'b1, 20);
    check_eq("sq_head", 32'(head), 32'h07);
    check_eq("sq_tail", 32'(tail), 32'h14);
    check_eq("sq_count", 32'(count), 32'd13);
    // Squash at tail leaves tail alone.
    step(4'b0000, 0, 1'b1, m_tail);

    // Reset mid-stream with count=50.
    apply_reset();
    for (int i = 0; i < 12; i++) step(4'b1111, 0, 1'b0, 0);
    step(4'b0011, 0, 1'b0, 0);
    check_eq("pre_rst_count", 32'(count), 32'd50);
    apply_reset();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      cnt  = m_tail - m_head;
      cmax = (c < 1500) ? 2 : COMMIT_WIDTH;
      if (cmax > cnt) cmax = cnt;
      cc   = int'($urandom_range(cmax, 0));
      n    = int'($urandom_range(ALLOC_WIDTH, 0));
      sq   = ($urandom_range(15, 0) == 0);
      sq_seq = sq ? int'($urandom_range(m_tail, m_head + cc)) : 0;
      step(ALLOC_WIDTH'((1 << n) - 1), cc, sq, sq_seq);
      if (c == 2200) apply_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
